code_output_packer: RTL and testbench

- Bit-packer for the entropy coder output stream.
- Each input beat carries a variable-length code (value plus bit count). The block concatenates the valid bits MSB-first into fixed-width output words on an AXI-Stream-style output.
- A flush request emits the final partial word, zero-padded, and then signals completion.
- Sits between the code/length synchronizer and the output sink.

---
 rtl/code_output_packer.sv | 102 ++++++++++
 tb/tb_code_output_packer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_output_packer.sv
// code_output_packer: packs variable-length codes MSB-first into
// fixed-width words, with a flush that drains the zero-padded tail.
module code_output_packer #(
  parameter int CODE_WIDTH       = 39,
  parameter int BIT_AMT_WIDTH    = 6,
  parameter int OUTPUT_WIDTH_LOG = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  output logic                          flushed,
  input  logic [CODE_WIDTH-1:0]         input_code_data,
  input  logic [BIT_AMT_WIDTH-1:0]      input_length_data,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic [2**OUTPUT_WIDTH_LOG-1:0] output_data,
  output logic                          output_valid,
  input  logic                          output_ready
);

  localparam int OW  = 2**OUTPUT_WIDTH_LOG;
  localparam int AW  = OW + CODE_WIDTH;
  localparam int OCW = $clog2(AW);

  localparam logic [BIT_AMT_WIDTH-1:0] CWL =
    BIT_AMT_WIDTH'(CODE_WIDTH);
  localparam logic [OCW-1:0] OWL = OCW'(OW);

  typedef enum logic {
    IDLE,
    FLUSHING
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]            acc_q, acc_d;
  logic [OCW-1:0]           occ_q, occ_d;
  logic [BIT_AMT_WIDTH-1:0] len_c;
  logic [BIT_AMT_WIDTH-1:0] pad;
  logic [CODE_WIDTH-1:0]    mask;
  logic [CODE_WIDTH-1:0]    code_al;
  logic [AW-1:0]            ins;
  logic                     in_fire;
  logic                     out_fire;

  assign len_c   = (input_length_data > CWL) ? CWL
                                             : input_length_data;
  assign mask    = ~({CODE_WIDTH{1'b1}} << len_c);
  assign pad     = CWL - len_c;
  assign code_al = (input_code_data & mask) << pad;
  assign ins     = {code_al, {OW{1'b0}}} >> occ_q;

  assign in_fire  = input_valid && input_ready;
  assign out_fire = output_valid && output_ready;

  assign output_data = acc_q[AW-1 -: OW];

  // State, accumulator and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      occ_q   <= occ_d;
    end
  end

  // Append on input beats, drop one word on output beats.
  always_comb begin
    acc_d = acc_q;
    occ_d = occ_q;
    if (out_fire) begin
      acc_d = acc_q << OW;
      occ_d = (occ_q >= OWL) ? occ_q - OWL : '0;
    end else if (in_fire) begin
      acc_d = acc_q | ins;
      occ_d = occ_q + OCW'(len_c);
    end
  end

  // Flush sequencing: enter on request, leave once drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (flush) state_d = FLUSHING;
      FLUSHING: if (occ_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake and completion outputs decoded from state.
  always_comb begin
    input_ready  = rst && (state_q == IDLE) && (occ_q < OWL);
    output_valid = (occ_q >= OWL) ||
                   ((state_q == FLUSHING) && (occ_q != '0));
    flushed      = (state_q == FLUSHING) && (occ_q == '0);
  end

endmodule

// File: tb/tb_code_output_packer.sv
// tb_code_output_packer: bit-queue reference model plus directed
// streams with hand-computed words for the packer.
module tb_code_output_packer;

  localparam int CW = 39;
  localparam int BW = 6;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          flushed;
  logic [CW-1:0] code = '0;
  logic [BW-1:0] len = '0;
  logic          iv = 1'b0;
  logic          ir;
  logic [OW-1:0] od;
  logic          ov;
  logic          ordy = 1'b1;

  code_output_packer dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .flushed           (flushed),
    .input_code_data   (code),
    .input_length_data (len),
    .input_valid       (iv),
    .input_ready       (ir),
    .output_data       (od),
    .output_valid      (ov),
    .output_ready      (ordy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          mq[$];
  bit          flushing_m = 1'b0;
  logic [31:0] words[$];
  logic [31:0] ref_w[$];
  int          flushed_cnt = 0;
  bit          rand_rdy = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_d = '0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int          n;
    int          l;
    bit          ev;
    bit          done;
    logic [31:0] ew;
    if (!rst) begin
      mq.delete();
      flushing_m = 1'b0;
      prev_stall = 1'b0;
      chk("rst_valid", 64'(ov), 0);
      chk("rst_ready", 64'(ir), 0);
      chk("rst_flushed", 64'(flushed), 0);
      chk("rst_data", 64'(od), 0);
    end else begin
      n  = mq.size();
      ev = (n >= OW) || (flushing_m && n > 0);
      ew = '0;
      for (int i = 0; i < OW; i++)
        if (i < n) ew[OW-1-i] = mq[i];
      chk("valid", 64'(ov), 64'(ev));
      chk("ready", 64'(ir), 64'(!flushing_m && n < OW));
      chk("flushed", 64'(flushed), 64'(flushing_m && n == 0));
      if (ev) chk("data", 64'(od), 64'(ew));
      if (prev_stall) chk("stall_hold", 64'(od), 64'(prev_d));
      prev_stall = ov && !ordy;
      prev_d     = od;
      if (ov && ordy) words.push_back(od);
      if (flushed) flushed_cnt++;
      if (ev && ordy)
        for (int i = 0; i < OW && mq.size() > 0; i++)
          void'(mq.pop_front());
      if (!flushing_m && n < OW && iv) begin
        l = (int'(len) > CW) ? CW : int'(len);
        for (int i = l - 1; i >= 0; i--) mq.push_back(code[i]);
      end
      done = flushing_m && n == 0;
      if (flush && !flushing_m) flushing_m = 1'b1;
      else if (done) flushing_m = 1'b0;
    end
  end

  initial begin : sink
    forever begin
      @(posedge clk);
      #1;
      ordy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(logic [CW-1:0] c, logic [BW-1:0] l);
    int t;
    t    = 0;
    code = c;
    len  = l;
    iv   = 1'b1;
    forever begin
      @(negedge clk);
      if (ir) break;
      t++;
      if (t > 2000) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    iv = 1'b0;
  endtask

  task automatic do_flush();
    int t;
    t     = 0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    forever begin
      @(negedge clk);
      if (flushed) break;
      t++;
      if (t > 2000) begin
        chk("flush_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stream39();
    for (int k = 1; k <= 39; k++) send(CW'(k), BW'(k));
    do_flush();
    idle(3);
  endtask

  initial begin : stim
    logic [CW-1:0] ones;
    ones = {CW{1'b1}};
    idle(3);
    rst = 1'b1;
    idle(2);

    words.delete();
    for (int k = 1; k <= 8; k++) send(CW'(k), BW'(k));
    idle(3);
    chk("t1_nwords", words.size(), 1);
    chk("t1_word0", 64'(words[0]), 64'h0000_0000_CD0A_3070);
    chk("t1_pending", mq.size(), 4);
    flushed_cnt = 0;
    do_flush();
    idle(2);
    chk("t1_nwords2", words.size(), 2);
    chk("t1_tail", 64'(words[1]), 64'h0000_0000_8000_0000);
    chk("t1_flushed", flushed_cnt, 1);

    words.delete();
    flushed_cnt = 0;
    stream39();
    chk("t2_nwords", words.size(), 25);
    chk("t2_last", 64'(words[24]), 64'h0000_0000_0270_0000);
    chk("t2_flushed", flushed_cnt, 1);
    ref_w = words;

    words.delete();
    flushed_cnt = 0;
    rand_rdy = 1'b1;
    stream39();
    rand_rdy = 1'b0;
    idle(2);
    chk("t3_nwords", words.size(), 25);
    for (int i = 0; i < 25; i++)
      chk($sformatf("t3_word%0d", i), 64'(words[i]),
          64'(ref_w[i]));
    chk("t3_flushed", flushed_cnt, 1);

    words.delete();
    send('0, 0);
    send(ones, 39);
    send(ones, 0);
    send(ones, 39);
    send(CW'(123), 0);
    send(ones, 63);
    do_flush();
    idle(2);
    chk("t4_nwords", words.size(), 4);
    chk("t4_w0", 64'(words[0]), 64'h0000_0000_FFFF_FFFF);
    chk("t4_w1", 64'(words[1]), 64'h0000_0000_FFFF_FFFF);
    chk("t4_w2", 64'(words[2]), 64'h0000_0000_FFFF_FFFF);
    chk("t4_w3", 64'(words[3]), 64'h0000_0000_FFFF_F800);

    words.delete();
    flushed_cnt = 0;
    do_flush();
    idle(3);
    chk("t5_nwords", words.size(), 0);
    chk("t5_flushed", flushed_cnt, 1);
    send(CW'(5), 3);
    do_flush();
    idle(2);
    chk("t5_nwords2", words.size(), 1);
    chk("t5_word", 64'(words[0]), 64'h0000_0000_A000_0000);

    send(CW'(21), 5);
    send(CW'(21), 5);
    send(CW'(21), 5);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 64'(ov), 0);
    chk("t6_ready", 64'(ir), 0);
    chk("t6_data", 64'(od), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    words.delete();
    for (int k = 1; k <= 8; k++) send(CW'(k), BW'(k));
    idle(3);
    chk("t6_nwords", words.size(), 1);
    chk("t6_word0", 64'(words[0]), 64'h0000_0000_CD0A_3070);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
